poly_mult_driver: RTL and testbench

Host-side initiator for the `poly_mult` core's load/busy interface on the CW305 target. It latches a 128-bit key and data operand from the register bank and pulses the core's load for a fixed number of cycles. It then tracks the core's busy window, captures the result one cycle after busy falls, and reports done, a timeout error and the busy-window cycle count. It also drives a scope trigger spanning the busy window for side-channel capture.

---
 rtl/poly_mult_drv_pkg.sv | 22 ++
 rtl/poly_mult_driver_sat_counter.sv | 24 ++
 rtl/poly_mult_driver.sv | 125 ++++++++++++
 tb/tb_poly_mult_driver.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_mult_drv_pkg.sv
// Shared types and defaults for the poly_mult host-side driver.
package poly_mult_drv_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_RUN,
        S_CAPTURE
    } drv_state_t;

    localparam int DEF_DATA_W      = 128;
    localparam int DEF_KEY_W       = 128;
    localparam int DEF_CNT_W       = 32;
    localparam int DEF_LOAD_CYCLES = 2;
    localparam int DEF_TIMEOUT     = 16;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/poly_mult_driver_sat_counter.sv
// Up-counter with synchronous clear, enable and saturation at all-ones.
module drv_sat_counter
    import poly_mult_drv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/poly_mult_driver.sv
// Load/busy initiator for the poly_mult core: latches operands, pulses
// load, times the busy window, captures the result and drives a trigger.
module poly_mult_driver
    import poly_mult_drv_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int KEY_W       = DEF_KEY_W,
    parameter int LOAD_CYCLES = DEF_LOAD_CYCLES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [KEY_W-1:0]  key_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              done_o,
    output logic              error_o,
    output logic [DATA_W-1:0] result_o,
    output logic [CNT_W-1:0]  cycles_o,
    output logic              trigger_o,
    output logic              core_load_o,
    output logic [KEY_W-1:0]  core_key_o,
    output logic [DATA_W-1:0] core_data_o,
    input  logic [DATA_W-1:0] core_data_i,
    input  logic              core_busy_i
);

    localparam int PH_W = $clog2(max2(LOAD_CYCLES, TIMEOUT) + 1);

    drv_state_t      state;
    logic [PH_W-1:0] phase;
    logic            busy_seen;
    logic            accept;
    logic            cnt_en;

    // Hold ready low during the done pulse so a new run never overlaps it.
    assign ready_o = (state == S_IDLE) && !done_o;
    assign accept  = ready_o && start_i;
    assign cnt_en  = core_busy_i &&
                     ((state == S_WAIT_BUSY) || (state == S_RUN));

    drv_sat_counter #(
        .W(CNT_W)
    ) u_busy_cnt (
        .clk  (clk),
        .rst_n(rst_n_i),
        .clr  (accept),
        .en   (cnt_en),
        .q    (cycles_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            phase       <= '0;
            busy_seen   <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            trigger_o   <= 1'b0;
            core_load_o <= 1'b0;
            result_o    <= '0;
            core_key_o  <= '0;
            core_data_o <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        core_key_o  <= key_i;
                        core_data_o <= data_i;
                        error_o     <= 1'b0;
                        busy_seen   <= 1'b0;
                        core_load_o <= 1'b1;
                        phase       <= PH_W'(LOAD_CYCLES);
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (core_busy_i) begin
                        busy_seen <= 1'b1;
                    end
                    if (phase == PH_W'(1)) begin
                        core_load_o <= 1'b0;
                        if (busy_seen || core_busy_i) begin
                            trigger_o <= 1'b1;
                            state     <= S_RUN;
                        end else begin
                            phase <= PH_W'(TIMEOUT);
                            state <= S_WAIT_BUSY;
                        end
                    end else begin
                        phase <= phase - PH_W'(1);
                    end
                end
                S_WAIT_BUSY: begin
                    if (core_busy_i) begin
                        trigger_o <= 1'b1;
                        state     <= S_RUN;
                    end else if (phase == PH_W'(1)) begin
                        error_o <= 1'b1;
                        done_o  <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        phase <= phase - PH_W'(1);
                    end
                end
                S_RUN: begin
                    if (!core_busy_i) begin
                        trigger_o <= 1'b0;
                        state     <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    result_o <= core_data_i;
                    done_o   <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_mult_driver.sv
// Scoreboard bench for poly_mult_driver with a behavioural echo core.
module tb_poly_mult_driver;

    typedef struct {
        int           inst;
        logic [127:0] res;
        logic [31:0]  cyc;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        start;
    logic [1:0][127:0] key;
    logic [1:0][127:0] data;
    logic [1:0]        ready, done, error, trig, load;
    logic [1:0][127:0] res, ckey, cdata;
    logic [1:0][127:0] cdin;
    logic [1:0]        busy   = '0;
    logic [1:0]        load_q = '0;
    logic [31:0]       cyc0;
    logic [3:0]        cyc1;

    int   mode [2];
    int   blen [2];
    int   remain [2];
    int   load_hi [2];
    int   trig_hi [2];
    int   done_cnt [2];
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb [$];
    exp_t e;

    localparam logic [127:0] K1 = 128'hDEADBEEF_12345678_DEADBEEF_12345678;
    localparam logic [127:0] D1 = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
    localparam logic [127:0] K2 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    localparam logic [127:0] D2 = 128'hA5A5_5A5A_F0F0_0F0F_1234_5678_9ABC_DEF0;
    localparam logic [127:0] K3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] D3 = 128'hCAFE_BABE_0000_FFFF_1357_9BDF_2468_ACE0;
    localparam logic [127:0] K4 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    localparam logic [127:0] D4 = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;

    poly_mult_driver u_dut0 (
        .clk        (clk),
        .rst_n_i    (rst_n),
        .start_i    (start[0]),
        .key_i      (key[0]),
        .data_i     (data[0]),
        .ready_o    (ready[0]),
        .done_o     (done[0]),
        .error_o    (error[0]),
        .result_o   (res[0]),
        .cycles_o   (cyc0),
        .trigger_o  (trig[0]),
        .core_load_o(load[0]),
        .core_key_o (ckey[0]),
        .core_data_o(cdata[0]),
        .core_data_i(cdin[0]),
        .core_busy_i(busy[0])
    );

    poly_mult_driver #(.CNT_W(4)) u_dut1 (
        .clk        (clk),
        .rst_n_i    (rst_n),
        .start_i    (start[1]),
        .key_i      (key[1]),
        .data_i     (data[1]),
        .ready_o    (ready[1]),
        .done_o     (done[1]),
        .error_o    (error[1]),
        .result_o   (res[1]),
        .cycles_o   (cyc1),
        .trigger_o  (trig[1]),
        .core_load_o(load[1]),
        .core_key_o (ckey[1]),
        .core_data_o(cdata[1]),
        .core_data_i(cdin[1]),
        .core_busy_i(busy[1])
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Core model: mode 0 busy after load ends, 1 never busy,
    // 2 busy from the second load cycle. Data output echoes operand.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            load_q[i] <= load[i];
            cdin[i]   <= cdata[i];
            if (busy[i]) begin
                if (remain[i] <= 1) busy[i] <= 1'b0;
                else remain[i] <= remain[i] - 1;
            end else if (mode[i] == 0 && load_q[i] && !load[i]) begin
                busy[i]   <= 1'b1;
                remain[i] <= blen[i];
            end else if (mode[i] == 2 && load[i] && !load_q[i]) begin
                busy[i]   <= 1'b1;
                remain[i] <= blen[i];
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (load[i]) load_hi[i]++;
            if (trig[i]) trig_hi[i]++;
            if (done[i]) begin
                done_cnt[i]++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_inst", i, e.inst);
                    chk("result", res[i], e.res);
                    chk("cycles", (i == 0) ? cyc0 : {28'b0, cyc1}, e.cyc);
                    chk("error", error[i], e.err);
                end
            end
        end
    end

    task automatic wait_done(input int i, output int t);
        t = 0;
        while (!done[i] && t < 400) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic run(input int i, input int m, input int len,
                       input logic [127:0] k, input logic [127:0] d,
                       input logic [127:0] eres, input logic [31:0] ecyc,
                       input logic eerr, input int elat, input int etrig);
        int t;
        mode[i] = m;
        blen[i] = len;
        t = 0;
        while (!ready[i] && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ready", ready[i], 1);
        start[i] = 1'b1;
        key[i]   = k;
        data[i]  = d;
        sb.push_back('{inst: i, res: eres, cyc: ecyc, err: eerr});
        load_hi[i]  = 0;
        trig_hi[i]  = 0;
        done_cnt[i] = 0;
        @(negedge clk);
        start[i] = 1'b0;
        wait_done(i, t);
        chk("latency", t, elat);
        @(negedge clk);
        chk("load_cycles", load_hi[i], 2);
        chk("trig_cycles", trig_hi[i], etrig);
        chk("done_pulses", done_cnt[i], 1);
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        start = '0;
        key   = '0;
        data  = '0;
        for (int i = 0; i < 2; i++) begin
            mode[i]     = 1;
            blen[i]     = 0;
            remain[i]   = 0;
            load_hi[i]  = 0;
            trig_hi[i]  = 0;
            done_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk("rst_ready", ready[0], 1);
        chk("rst_done", done[0], 0);
        chk("rst_error", error[0], 0);
        chk("rst_trig", trig[0], 0);
        chk("rst_load", load[0], 0);
        chk("rst_result", res[0], 0);
        chk("rst_cycles", cyc0, 0);
        chk("rst_key", ckey[0], 0);
        chk("rst_data", cdata[0], 0);
        chk("rst_ready1", ready[1], 1);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 0, 20, K1, D1, D1, 20, 1'b0, 25, 20);
        chk("echo_key", ckey[0], K1);

        run(0, 1, 0, K2, D4, D1, 0, 1'b1, 18, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", error[0], 1);

        run(0, 2, 6, K2, D2, D2, 5, 1'b0, 9, 6);
        chk("err_cleared", error[0], 0);

        mode[0] = 0;
        blen[0] = 5;
        start[0] = 1'b1;
        key[0]   = K3;
        data[0]  = D3;
        sb.push_back('{inst: 0, res: D3, cyc: 5, err: 1'b0});
        @(negedge clk);
        key[0]  = K4;
        data[0] = D4;
        wait_done(0, t);
        chk("hold_done", done[0], 1);
        chk("hold_key", ckey[0], K3);
        chk("hold_data", cdata[0], D3);
        sb.push_back('{inst: 0, res: D4, cyc: 5, err: 1'b0});
        t = 0;
        while (!load[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        start[0] = 1'b0;
        chk("hold_reaccept", load[0], 1);
        wait_done(0, t);
        chk("hold_done2", done[0], 1);
        chk("hold_key2", ckey[0], K4);
        repeat (2) @(negedge clk);

        mode[0] = 0;
        blen[0] = 20;
        start[0] = 1'b1;
        key[0]   = K4;
        data[0]  = D4;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_trig", trig[0], 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_ready", ready[0], 1);
        chk("mrst_done", done[0], 0);
        chk("mrst_error", error[0], 0);
        chk("mrst_trig", trig[0], 0);
        chk("mrst_load", load[0], 0);
        chk("mrst_result", res[0], 0);
        chk("mrst_cycles", cyc0, 0);
        chk("mrst_key", ckey[0], 0);
        chk("mrst_data", cdata[0], 0);
        repeat (30) @(negedge clk);

        run(0, 0, 20, K3, D3, D3, 20, 1'b0, 25, 20);

        run(1, 0, 20, K1, D1, D1, 15, 1'b0, 25, 20);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
